fixed_linear_bias_add: RTL and testbench

//  Downstream consumer of the per-layer bias source ROMs. Joins the matmul result

---
 rtl/fixed_arith_pkg.sv | 51 +++++
 rtl/fixed_skid_buffer.sv | 58 +++++
 rtl/fixed_linear_bias_add.sv | 104 ++++++++++
 tb/tb_fixed_linear_bias_add.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_arith_pkg.sv
// rtl/fixed_arith_pkg.sv - fixed-point alignment, round-half-up and saturation helpers
package fixed_arith_pkg;

  localparam int ACC_W = 64;

  typedef logic signed [ACC_W-1:0] acc_t;

  typedef struct packed {
    logic sat;
    acc_t value;
  } ars_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int common_frac(input int a_frac, input int b_frac);
    return max_int(a_frac, b_frac);
  endfunction

  // One guard bit on top of the widest integer part so the sum cannot overflow.
  function automatic int common_width(input int a_w, input int a_frac,
                                      input int b_w, input int b_frac);
    return max_int(a_w - a_frac, b_w - b_frac) + common_frac(a_frac, b_frac) + 1;
  endfunction

  function automatic ars_t align_round_sat(input acc_t value, input int in_frac,
                                           input int out_w, input int out_frac);
    acc_t v;
    acc_t hi;
    acc_t lo;
    ars_t r;
    if (out_frac < in_frac)
      v = (value + (acc_t'(1) <<< (in_frac - out_frac - 1))) >>> (in_frac - out_frac);
    else
      v = value <<< (out_frac - in_frac);
    hi = (acc_t'(1) <<< (out_w - 1)) - acc_t'(1);
    lo = -(acc_t'(1) <<< (out_w - 1));
    r.sat   = 1'b0;
    r.value = v;
    if (v > hi) begin
      r.sat   = 1'b1;
      r.value = hi;
    end else if (v < lo) begin
      r.sat   = 1'b1;
      r.value = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_skid_buffer.sv
// rtl/fixed_skid_buffer.sv - 2-entry registered skid buffer with registered input ready
module fixed_skid_buffer #(
  parameter int DATA_WIDTH = 65
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready
);

  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_valid;
  logic                  push;
  logic                  pop;

  assign push = s_tvalid & s_tready;
  assign pop  = m_tvalid & m_tready;

  // m_tdata is the head entry, skid_data the second; s_tready is "not full next cycle".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      s_tready   <= 1'b0;
    end else begin
      if (skid_valid) begin
        if (pop) begin
          m_tdata    <= skid_data;
          skid_valid <= 1'b0;
        end
        s_tready <= pop;
      end else if (m_tvalid) begin
        if (pop && push) begin
          m_tdata <= s_tdata;
        end else if (pop) begin
          m_tvalid <= 1'b0;
        end else if (push) begin
          skid_data  <= s_tdata;
          skid_valid <= 1'b1;
        end
        s_tready <= !(push && !pop);
      end else begin
        if (push) begin
          m_tdata  <= s_tdata;
          m_tvalid <= 1'b1;
        end
        s_tready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fixed_linear_bias_add.sv
// rtl/fixed_linear_bias_add.sv - joins matmul and bias streams, per-lane aligned saturating add
module fixed_linear_bias_add
  import fixed_arith_pkg::*;
#(
  parameter int DATA_IN_PRECISION_0  = 16,
  parameter int DATA_IN_PRECISION_1  = 3,
  parameter int BIAS_PRECISION_0     = 16,
  parameter int BIAS_PRECISION_1     = 3,
  parameter int DATA_OUT_PRECISION_0 = 16,
  parameter int DATA_OUT_PRECISION_1 = 3,
  parameter int TENSOR_SIZE_DIM_0    = 32,
  parameter int PARALLELISM_DIM_0    = 4
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [PARALLELISM_DIM_0*DATA_IN_PRECISION_0-1:0]  data_in,
  input  logic                                              data_in_valid,
  output logic                                              data_in_ready,
  input  logic [PARALLELISM_DIM_0*BIAS_PRECISION_0-1:0]     bias,
  input  logic                                              bias_valid,
  output logic                                              bias_ready,
  output logic [PARALLELISM_DIM_0*DATA_OUT_PRECISION_0-1:0] data_out,
  output logic                                              data_out_valid,
  input  logic                                              data_out_ready,
  output logic                                              data_out_last,
  output logic                                              sat_flag
);

  localparam int P         = PARALLELISM_DIM_0;
  localparam int DIN_W     = DATA_IN_PRECISION_0;
  localparam int BIAS_W    = BIAS_PRECISION_0;
  localparam int DOUT_W    = DATA_OUT_PRECISION_0;
  localparam int OUT_DEPTH = TENSOR_SIZE_DIM_0 / P;
  localparam int IDX_W     = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int F         = common_frac(DATA_IN_PRECISION_1, BIAS_PRECISION_1);
  localparam int W         = common_width(DIN_W, DATA_IN_PRECISION_1, BIAS_W, BIAS_PRECISION_1);
  localparam int BUF_W     = P * DOUT_W + 1;

  logic              can_accept;
  logic              both_valid;
  logic              xfer;
  logic [P*DOUT_W-1:0] lane_result;
  logic [P-1:0]      lane_sat;
  logic [IDX_W-1:0]  blk_idx;
  logic              blk_last;
  logic [BUF_W-1:0]  buf_out;

  // Neither stream moves alone, keeping the bias source block-aligned with the data.
  assign both_valid    = data_in_valid & bias_valid;
  assign xfer          = both_valid & can_accept;
  assign data_in_ready = bias_valid & can_accept;
  assign bias_ready    = data_in_valid & can_accept;

  for (genvar i = 0; i < P; i++) begin : g_lane
    logic signed [W-1:0] din_al;
    logic signed [W-1:0] bias_al;
    logic signed [W-1:0] sum;
    ars_t                res;
    logic                lane_unused;

    always_comb begin
      din_al  = W'($signed(data_in[i*DIN_W +: DIN_W])) <<< (F - DATA_IN_PRECISION_1);
      bias_al = W'($signed(bias[i*BIAS_W +: BIAS_W])) <<< (F - BIAS_PRECISION_1);
      sum     = din_al + bias_al;
      res     = align_round_sat(acc_t'(sum), F, DOUT_W, DATA_OUT_PRECISION_1);
    end

    assign lane_result[i*DOUT_W +: DOUT_W] = res.value[DOUT_W-1:0];
    assign lane_sat[i]                     = res.sat;
    assign lane_unused                     = ^res.value[ACC_W-1:DOUT_W];
  end

  assign blk_last = (blk_idx == IDX_W'(OUT_DEPTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_idx  <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (xfer) begin
        blk_idx <= blk_last ? '0 : blk_idx + 1'b1;
        if (|lane_sat)
          sat_flag <= 1'b1;
      end
    end
  end

  fixed_skid_buffer #(
    .DATA_WIDTH(BUF_W)
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  ({blk_last, lane_result}),
    .s_tvalid (both_valid),
    .s_tready (can_accept),
    .m_tdata  (buf_out),
    .m_tvalid (data_out_valid),
    .m_tready (data_out_ready)
  );

  assign data_out      = buf_out[P*DOUT_W-1:0];
  assign data_out_last = buf_out[BUF_W-1];

endmodule

// File: tb/tb_fixed_linear_bias_add.sv
// tb/tb_fixed_linear_bias_add.sv - randomized bench with a real-arithmetic reference model
module tb_fixed_linear_bias_add;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data_in, bias, data_out;
  logic        data_in_valid, data_in_ready, bias_valid, bias_ready;
  logic        data_out_valid, data_out_ready, data_out_last, sat_flag;

  logic [63:0] mx_din, mx_bias, mx_out;
  logic        mx_din_valid, mx_din_ready, mx_bias_valid, mx_bias_ready;
  logic        mx_out_valid, mx_out_ready, mx_out_last, mx_sat;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fixed_linear_bias_add u_dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .bias(bias), .bias_valid(bias_valid), .bias_ready(bias_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .data_out_last(data_out_last), .sat_flag(sat_flag)
  );

  fixed_linear_bias_add #(.BIAS_PRECISION_1(5)) u_mix (
    .clk(clk), .rst(rst),
    .data_in(mx_din), .data_in_valid(mx_din_valid), .data_in_ready(mx_din_ready),
    .bias(mx_bias), .bias_valid(mx_bias_valid), .bias_ready(mx_bias_ready),
    .data_out(mx_out), .data_out_valid(mx_out_valid), .data_out_ready(mx_out_ready),
    .data_out_last(mx_out_last), .sat_flag(mx_sat)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Real-valued sum, rounded half up at the output scale, then clamped.
  function automatic logic [15:0] ref_lane(input int d, input int b, input int df,
                                           input int bf, input int of, output bit sat);
    real    x;
    real    r;
    longint v;
    x = real'(d) / real'(1 << df) + real'(b) / real'(1 << bf);
    r = $floor(x * real'(1 << of) + 0.5);
    v = longint'(r);
    sat = 1'b0;
    if (v > 32767) begin v = 32767; sat = 1'b1; end
    if (v < -32768) begin v = -32768; sat = 1'b1; end
    return v[15:0];
  endfunction

  function automatic logic [63:0] ref_block(input logic [63:0] d, input logic [63:0] b,
                                            input int bf, output bit sat_any);
    bit                s;
    logic signed [15:0] dl, bl;
    logic [63:0]       res;
    sat_any = 1'b0;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      dl = d[i*16 +: 16];
      bl = b[i*16 +: 16];
      res[i*16 +: 16] = ref_lane(int'(dl), int'(bl), 3, bf, 3, s);
      sat_any |= s;
    end
    return res;
  endfunction

  function automatic logic [15:0] rand_val();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 16'h7fff;
    if (r == 1) return 16'h8000;
    if (r < 5) return 16'($urandom);
    return 16'($urandom_range(0, 511)) - 16'd256;
  endfunction

  typedef struct {
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   m_idx = 0;
  bit   m_sat = 1'b0;
  bit   ready_ok = 1'b0;
  bit   mon_blk_sat;
  logic mon_can;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_valid", 64'(data_out_valid), 64'd0);
      chk("rst_data", data_out, 64'd0);
      chk("rst_last", 64'(data_out_last), 64'd0);
      chk("rst_sat", 64'(sat_flag), 64'd0);
      chk("rst_in_ready", 64'(data_in_ready), 64'd0);
      q.delete();
      m_idx = 0;
      m_sat = 1'b0;
      ready_ok = 1'b0;
    end else begin
      mon_can = ready_ok && (q.size() < 2);
      chk("in_ready", 64'(data_in_ready), 64'(bias_valid & mon_can));
      chk("bias_ready", 64'(bias_ready), 64'(data_in_valid & mon_can));
      chk("out_valid", 64'(data_out_valid), 64'(q.size() > 0));
      chk("sat_flag", 64'(sat_flag), 64'(m_sat));
      if (data_out_valid && q.size() > 0) begin
        chk("out_data", data_out, q[0].data);
        chk("out_last", 64'(data_out_last), 64'(q[0].last));
        if (data_out_ready) void'(q.pop_front());
      end
      if (data_in_valid && bias_valid && data_in_ready && bias_ready) begin
        mon_e.data = ref_block(data_in, bias, 3, mon_blk_sat);
        mon_e.last = (m_idx == DEPTH - 1);
        q.push_back(mon_e);
        m_idx = (m_idx + 1) % DEPTH;
        if (mon_blk_sat) m_sat = 1'b1;
      end
      ready_ok = 1'b1;
    end
  end

  task automatic send_check(input string name, input logic [63:0] d, input logic [63:0] b,
                            input logic [63:0] exp);
    int g;
    g = 0;
    data_in = d;
    bias = b;
    data_in_valid = 1'b1;
    bias_valid = 1'b1;
    for (int i = 0; i < 20 && g == 0; i++) begin
      @(negedge clk);
      g = (data_in_ready && bias_ready) ? 1 : 0;
    end
    chk({name, "_handshake"}, 64'(g), 64'd1);
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    bias_valid = 1'b0;
    @(negedge clk);
    chk(name, data_out, exp);
  endtask

  int          got;
  int          outs;
  int          first_last;
  logic [63:0] held;

  initial begin
    data_in = '0; bias = '0; data_in_valid = 0; bias_valid = 0; data_out_ready = 1;
    mx_din = '0; mx_bias = '0; mx_din_valid = 0; mx_bias_valid = 0; mx_out_ready = 1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // precision mix: 0.125 + 0.09375 -> 0.25, and the negated case -> -0.25
    mx_din = {4{16'd1}}; mx_bias = {4{16'd3}}; mx_din_valid = 1; mx_bias_valid = 1;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      got = (mx_din_ready && mx_bias_ready) ? 1 : 0;
    end
    chk("mix_handshake", 64'(got), 64'd1);
    @(posedge clk);
    #1 mx_din = {4{16'hffff}}; mx_bias = {4{16'hfffd}};
    @(negedge clk);
    chk("mix_pos", mx_out, {4{16'd2}});
    chk("mix_pos_valid", 64'(mx_out_valid), 64'd1);
    @(posedge clk);
    #1 mx_din_valid = 0; mx_bias_valid = 0;
    @(negedge clk);
    chk("mix_neg", mx_out, {4{16'hfffe}});

    // steady stream 1.0 + 2.0
    data_in = {4{16'd8}}; bias = {4{16'd16}}; data_in_valid = 1; bias_valid = 1;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      got = (data_in_ready && bias_ready) ? 1 : 0;
    end
    chk("steady_handshake", 64'(got), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("steady_out", data_out, {4{16'd24}});
      chk("steady_valid", 64'(data_out_valid), 64'd1);
    end
    @(posedge clk);
    #1;

    // saturation both ways
    send_check("sat_pos", {4{16'h7fff}}, {4{16'd1}}, {4{16'h7fff}});
    chk("sat_flag_set", 64'(sat_flag), 64'd1);
    send_check("sat_neg", {4{16'h8000}}, {4{16'hffff}}, {4{16'h8000}});

    // backpressure mid-row
    data_in_valid = 1; bias_valid = 1; bias = {4{16'd1}};
    for (int c = 0; c < 14; c++) begin
      data_in = {4{16'(c * 8)}};
      data_out_ready = !(c >= 3 && c < 8);
      @(negedge clk);
      if (c == 4) held = data_out;
      if (c > 4 && c < 8) chk("bp_hold", data_out, held);
      if (c == 5) chk("bp_ready_drop", 64'(data_in_ready | bias_ready), 64'd0);
      @(posedge clk);
      #1;
    end

    // fill the buffer, then reset mid-row
    data_out_ready = 0; data_in = {4{16'd40}};
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("full_ready_low", 64'(data_in_ready), 64'd0);
    chk("full_valid", 64'(data_out_valid), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rst_async_valid", 64'(data_out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // join skew after reset: last must land on the 8th output
    data_out_ready = 1; bias_valid = 1; outs = 0; first_last = 0;
    for (int c = 0; c < 40; c++) begin
      data_in_valid = (c % 2 == 0);
      data_in = {4{16'(c)}};
      bias = {rand_val(), rand_val(), rand_val(), rand_val()};
      @(negedge clk);
      if (data_out_valid && data_out_ready) begin
        outs++;
        if (data_out_last && first_last == 0) first_last = outs;
      end
      @(posedge clk);
      #1;
    end
    chk("last_on_block8", 64'(first_last), 64'd8);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      data_in_valid = ($urandom_range(0, 3) != 0);
      bias_valid = ($urandom_range(0, 3) != 0);
      data_out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        data_in[i*16 +: 16] = rand_val();
        bias[i*16 +: 16] = rand_val();
      end
      @(posedge clk);
      #1;
    end

    data_in_valid = 0; bias_valid = 0; data_out_ready = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_valid", 64'(data_out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
